// File: rtl/i2c_pkg.sv
// Shared types and the default codec register table for the I2C configuration sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    LOAD,
    START,
    WAIT_DONE,
    GAP,
    DONE,
    ERROR
  } state_t;

  typedef logic [15:0] cfg_word_t;

  localparam int TABLE_DEPTH = 32;

  // Entries past the codec setup list are zero so any legal index reads a defined word.
  localparam cfg_word_t CFG_TABLE [TABLE_DEPTH] = '{
    0: 16'h1E00,
    1: 16'h0017,
    2: 16'h0217,
    3: 16'h0479,
    4: 16'h0679,
    5: 16'h0810,
    6: 16'h0A00,
    7: 16'h0C00,
    8: 16'h0E42,
    9: 16'h1201,
    default: 16'h0000
  };

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Combinational index-to-word lookup into the package configuration table.
module i2c_cfg_rom
  import i2c_pkg::*;
(
  input  logic [4:0] i_index,
  output cfg_word_t  o_word
);

  assign o_word = CFG_TABLE[i_index];

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks the codec register table after power-up, handing one write per word to an I2C transmitter.
module i2c_cfg_seq
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         N_REGS         = 10,
  parameter int         PWRUP_CYCLES   = 1000,
  parameter int         GAP_CYCLES     = 64,
  parameter int         ACCEPT_TIMEOUT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic        i_ready,
  output logic        o_start,
  output logic [6:0]  o_addr,
  output logic        o_mode,
  output logic [15:0] o_reg_data,
  output logic [4:0]  o_index,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  // Zero-length waits collapse to a single cycle so every countdown terminates.
  localparam int PWR_EFF = (PWRUP_CYCLES   < 1) ? 1 : PWRUP_CYCLES;
  localparam int GAP_EFF = (GAP_CYCLES     < 1) ? 1 : GAP_CYCLES;
  localparam int TMO_EFF = (ACCEPT_TIMEOUT < 1) ? 1 : ACCEPT_TIMEOUT;
  localparam int CNT_MAX = max3(PWR_EFF, GAP_EFF, TMO_EFF);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(PWR_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TMO_EFF - 1);
  localparam logic [4:0]       LAST_IDX = 5'(N_REGS - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_index, w_index_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_start;
  cfg_word_t        r_reg_data;
  cfg_word_t        w_rom_word;
  logic             w_load;

  i2c_cfg_rom u_rom (
    .i_index (r_index),
    .o_word  (w_rom_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_go) begin
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_index_nxt = '0;
          w_cnt_nxt   = PWR_LD;
          w_state_nxt = PWRUP;
        end
      end
      PWRUP: begin
        if (r_cnt == '0) w_state_nxt = LOAD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      LOAD: begin
        w_load      = 1'b1;
        w_cnt_nxt   = TMO_LD;
        w_state_nxt = START;
      end
      START: begin
        // Acceptance is tested first so a last-cycle handshake is never reported as a timeout.
        if (!i_ready) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == '0) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ERROR;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i_ready) begin
          if (r_index == LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_index_nxt = r_index + 1'b1;
            w_cnt_nxt   = GAP_LD;
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (r_cnt == '0) w_state_nxt = LOAD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_index    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_reg_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_index <= w_index_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_start <= (w_state_nxt == START);
      if (w_load) r_reg_data <= w_rom_word;
    end
  end

  assign o_start    = r_start;
  assign o_addr     = DEV_ADDR;
  assign o_mode     = 1'b0;
  assign o_reg_data = r_reg_data;
  assign o_index    = r_index;
  assign o_busy     = !(r_state inside {IDLE, DONE, ERROR});
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Scoreboard bench: three sequencer instances (full table, short timeout, single word).
module tb_i2c_cfg_seq;

  localparam int PA = 20;
  localparam int GA = 8;
  localparam int PB = 4;
  localparam int GB = 2;
  localparam int TB = 16;
  localparam int PC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_tab [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0810, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201};

  logic go_a, rdy_a, start_a, mode_a, busy_a, done_a, err_a;
  logic go_b, rdy_b, start_b, mode_b, busy_b, done_b, err_b;
  logic go_c, rdy_c, start_c, mode_c, busy_c, done_c, err_c;
  logic [6:0]  addr_a, addr_b, addr_c;
  logic [15:0] data_a, data_b, data_c;
  logic [4:0]  idx_a, idx_b, idx_c;

  i2c_cfg_seq #(.N_REGS(10), .PWRUP_CYCLES(PA), .GAP_CYCLES(GA)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_go(go_a), .i_ready(rdy_a), .o_start(start_a),
    .o_addr(addr_a), .o_mode(mode_a), .o_reg_data(data_a), .o_index(idx_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a));

  i2c_cfg_seq #(.N_REGS(2), .PWRUP_CYCLES(PB), .GAP_CYCLES(GB), .ACCEPT_TIMEOUT(TB)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_go(go_b), .i_ready(rdy_b), .o_start(start_b),
    .o_addr(addr_b), .o_mode(mode_b), .o_reg_data(data_b), .o_index(idx_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b));

  i2c_cfg_seq #(.N_REGS(1), .PWRUP_CYCLES(PC), .GAP_CYCLES(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_go(go_c), .i_ready(rdy_c), .o_start(start_c),
    .o_addr(addr_c), .o_mode(mode_c), .o_reg_data(data_c), .o_index(idx_c),
    .o_busy(busy_c), .o_done(done_c), .o_err(err_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {index, word} per o_start rise, pushed by the stimulus process.
  logic [20:0] qa[$];
  logic [20:0] qb[$];
  logic [20:0] qc[$];
  bit first_a = 1'b0;
  int go_cyc_a = 0;
  int pulses_a = 0;
  int pulses_c = 0;

  // Transmitter model: busy 3 cycles after a request, idle again 50 cycles later.
  initial begin
    rdy_a = 1'b1;
    forever begin
      @(negedge clk);
      if (start_a && rdy_a) begin
        repeat (3) @(negedge clk);
        rdy_a = 1'b0;
        repeat (50) @(negedge clk);
        rdy_a = 1'b1;
      end
    end
  end

  initial begin
    rdy_c = 1'b1;
    forever begin
      @(negedge clk);
      if (start_c && rdy_c) begin
        repeat (3) @(negedge clk);
        rdy_c = 1'b0;
        repeat (50) @(negedge clk);
        rdy_c = 1'b1;
      end
    end
  end

  initial begin
    logic prev;
    int   last_rise;
    logic [20:0] e;
    prev = 1'b0;
    last_rise = 0;
    forever begin
      @(negedge clk);
      if (start_a && !prev) begin
        pulses_a++;
        chk("a_queue_has_entry", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_idx_word", 32'({idx_a, data_a}), 32'(e));
        end
        chk("a_addr", 32'(addr_a), 32'h1A);
        chk("a_mode", 32'(mode_a), 0);
        if (first_a) begin
          chk("a_pwrup_latency_ok", 32'((cyc - go_cyc_a) >= PA + 1), 1);
          first_a = 1'b0;
        end else begin
          chk("a_cmd_spacing_ok", 32'((cyc - last_rise) >= GA + 2), 1);
        end
        last_rise = cyc;
      end
      prev = start_a;
    end
  end

  initial begin
    logic prev;
    logic [20:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (start_b && !prev) begin
        chk("b_queue_has_entry", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_idx_word", 32'({idx_b, data_b}), 32'(e));
        end
        chk("b_addr", 32'(addr_b), 32'h1A);
        chk("b_mode", 32'(mode_b), 0);
      end
      prev = start_b;
    end
  end

  initial begin
    logic prev;
    logic [20:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (start_c && !prev) begin
        pulses_c++;
        chk("c_queue_has_entry", 32'(qc.size() > 0), 1);
        if (qc.size() > 0) begin
          e = qc.pop_front();
          chk("c_idx_word", 32'({idx_c, data_c}), 32'(e));
        end
        chk("c_addr", 32'(addr_c), 32'h1A);
        chk("c_mode", 32'(mode_c), 0);
      end
      prev = start_c;
    end
  end

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) qa.push_back({5'(i), exp_tab[i]});
  endtask

  initial begin
    int n;
    int hi;
    rst = 1'b1; go_a = 1'b0; go_b = 1'b0; go_c = 1'b0; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start",  32'(start_a), 0);
    chk("rst_busy",   32'(busy_a), 0);
    chk("rst_done",   32'(done_a), 0);
    chk("rst_err",    32'(err_a), 0);
    chk("rst_index",  32'(idx_a), 0);
    chk("rst_data",   32'(data_a), 0);
    chk("rst_addr",   32'(addr_a), 32'h1A);
    chk("rst_mode",   32'(mode_a), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-word table.
    qc.push_back({5'd0, 16'h1E00});
    go_c = 1'b1; @(negedge clk); go_c = 1'b0;
    n = 0; while (!done_c && n < 500) begin @(negedge clk); n++; end
    chk("c_done",    32'(done_c), 1);
    chk("c_busy",    32'(busy_c), 0);
    chk("c_err",     32'(err_c), 0);
    chk("c_index",   32'(idx_c), 0);
    chk("c_pulses",  32'(pulses_c), 1);
    chk("c_q_empty", 32'(qc.size()), 0);

    // Accept timeout with the transmitter never starting.
    qb.push_back({5'd0, 16'h1E00});
    go_b = 1'b1; @(negedge clk); go_b = 1'b0;
    n = 0; while (!start_b && n < 100) begin @(negedge clk); n++; end
    hi = 0; while (start_b && hi < 100) begin @(negedge clk); hi++; end
    chk("b_start_width", 32'(hi), TB);
    chk("b_err",   32'(err_b), 1);
    chk("b_busy",  32'(busy_b), 0);
    chk("b_done",  32'(done_b), 0);
    chk("b_index", 32'(idx_b), 0);

    // Rerun from ERROR; word 0 accepted on the timeout cycle, word 1 times out.
    qb.push_back({5'd0, 16'h1E00});
    qb.push_back({5'd1, 16'h0017});
    go_b = 1'b1; @(negedge clk); go_b = 1'b0;
    chk("b_err_cleared", 32'(err_b), 0);
    chk("b_busy_run2",   32'(busy_b), 1);
    n = 0; while (!start_b && n < 100) begin @(negedge clk); n++; end
    repeat (TB - 1) @(negedge clk);
    rdy_b = 1'b0;
    @(negedge clk);
    chk("b_late_accept_start", 32'(start_b), 0);
    chk("b_late_accept_noerr", 32'(err_b), 0);
    chk("b_late_accept_busy",  32'(busy_b), 1);
    repeat (3) @(negedge clk);
    rdy_b = 1'b1;
    n = 0; while (!err_b && n < 200) begin @(negedge clk); n++; end
    chk("b_word1_err",   32'(err_b), 1);
    chk("b_word1_index", 32'(idx_b), 1);
    chk("b_word1_busy",  32'(busy_b), 0);
    chk("b_q_empty",     32'(qb.size()), 0);

    // Full table, with a stray go while busy.
    pulses_a = 0; push_a(10); first_a = 1'b1; go_cyc_a = cyc + 1;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    n = 0; while (idx_a != 5'd4 && n < 2000) begin @(negedge clk); n++; end
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    n = 0; while (!done_a && n < 3000) begin @(negedge clk); n++; end
    chk("a_run1_done",   32'(done_a), 1);
    chk("a_run1_busy",   32'(busy_a), 0);
    chk("a_run1_err",    32'(err_a), 0);
    chk("a_run1_pulses", 32'(pulses_a), 10);
    chk("a_run1_q",      32'(qa.size()), 0);

    // Rerun after DONE.
    pulses_a = 0; push_a(10); first_a = 1'b1; go_cyc_a = cyc + 1;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    chk("a_run2_done_cleared", 32'(done_a), 0);
    chk("a_run2_busy",         32'(busy_a), 1);
    n = 0; while (!done_a && n < 3000) begin @(negedge clk); n++; end
    chk("a_run2_done",   32'(done_a), 1);
    chk("a_run2_pulses", 32'(pulses_a), 10);

    // Reset while waiting on word 5.
    pulses_a = 0; push_a(6); first_a = 1'b1; go_cyc_a = cyc + 1;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    n = 0;
    while (!(idx_a == 5'd5 && busy_a && !start_a && !rdy_a) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("a_reached_word5_wait", 32'(idx_a == 5'd5 && !rdy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("a_mid_rst_start", 32'(start_a), 0);
    chk("a_mid_rst_index", 32'(idx_a), 0);
    chk("a_mid_rst_busy",  32'(busy_a), 0);
    chk("a_mid_rst_done",  32'(done_a), 0);
    chk("a_mid_rst_data",  32'(data_a), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("a_run3_pulses", 32'(pulses_a), 6);
    chk("a_run3_q",      32'(qa.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C slave address placed on o_addr for every command.
REQ-002 Parameter N_REGS, default 10, number of configuration words; legal range 1..32.
REQ-003 Parameter PWRUP_CYCLES, default 1000, i_clk cycles waited after i_go before the first command.
REQ-004 Parameter GAP_CYCLES, default 64, idle i_clk cycles inserted between consecutive commands.
REQ-005 Parameter ACCEPT_TIMEOUT, default 4096, maximum i_clk cycles o_start may be held without i_ready falling.
REQ-006 Clocking and reset (already decided): one clock; reset is synchronous and active-high.
REQ-007 i_clk  input  1  system clock; all logic on its rising edge.
REQ-008 i_rst  input  1  synchronous, active-high reset.
REQ-009 i_go  input  1  single-cycle request to run the full configuration sequence.
REQ-010 i_ready  input  1  transmitter ready; high = idle, low = transfer in progress.
REQ-011 o_start  output  1  transfer request to the transmitter, held until accepted.
REQ-012 o_addr  output  7  slave address; constant DEV_ADDR.
REQ-013 o_mode  output  1  R/W bit; constant 0 (write).
REQ-014 o_reg_data  output  16  current configuration word from the table.
REQ-015 o_index  output  5  index of the word currently loaded, 0..N_REGS-1.
REQ-016 o_busy  output  1  high whenever the state is not IDLE, DONE or ERROR.
REQ-017 o_done  output  1  sticky; set when all N_REGS words have been sent.
REQ-018 o_err  output  1  sticky; set on accept timeout.

Function
REQ-019 States: IDLE, PWRUP, LOAD, START, WAIT_DONE, GAP, DONE, ERROR.
REQ-020 In IDLE, DONE or ERROR, i_go=1 clears o_done, o_err and o_index, loads the counter with PWRUP_CYCLES-1 and enters PWRUP.
REQ-021 While busy, i_go is ignored.
REQ-022 PWRUP decrements the counter each cycle and enters LOAD when the counter reaches 0.
REQ-023 LOAD registers table[o_index] into o_reg_data, loads the timeout counter and enters START one cycle later.
REQ-024 START drives o_start=1 with o_addr, o_mode and o_reg_data stable.
REQ-025 In START, when i_ready is sampled 0, o_start drops in the same registered update and the state becomes WAIT_DONE.
REQ-026 If the timeout counter expires in START, o_start drops, o_err is set and the state becomes ERROR.
REQ-027 WAIT_DONE waits for i_ready=1.
REQ-028 On i_ready=1 in WAIT_DONE: if o_index=N_REGS-1, enter DONE and set o_done; otherwise increment o_index, load GAP_CYCLES-1 and enter GAP.
REQ-029 GAP counts down to 0, then enters LOAD; GAP_CYCLES=0 is treated as 1.
REQ-030 o_start is registered, never combinational, and is high only in START.
REQ-031 o_reg_data is unchanged from LOAD until the next LOAD.
REQ-032 Counter widths are sized by $clog2 of the largest of PWRUP_CYCLES, GAP_CYCLES and ACCEPT_TIMEOUT.
REQ-033 o_index does not wrap past N_REGS-1.
REQ-034 Simultaneous timeout expiry and i_ready=0 in START: acceptance wins and no error is flagged.

Reset
REQ-035 i_rst=1 forces, on the next edge: state IDLE, o_start=0, o_reg_data=0, o_index=0, o_busy=0, o_done=0, o_err=0, all counters 0.
REQ-036 Reset mid-transfer drops o_start immediately; no recovery of the transmitter is attempted.
REQ-037 o_addr and o_mode are constants and are unaffected by reset.

Structure
REQ-038 Package i2c_pkg holds the state enum, a cfg_word_t typedef (16 bits) and the default codec register table as a constant array of 32 entries.
REQ-039 Default table entries 0..9: 16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0810, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201.
REQ-040 One sub-module, i2c_cfg_rom: combinational index-to-word lookup into the package table, instanced once.

Verification
REQ-041 Reset, then i_go with a transmitter model that drops i_ready 3 cycles after o_start and raises it 50 cycles later -> exactly 10 o_start pulses, o_reg_data values in table order, o_done=1 and o_busy=0 at the end.
REQ-042 First o_start rises no earlier than PWRUP_CYCLES+1 cycles after i_go; consecutive o_start rises are at least GAP_CYCLES+2 cycles apart.
REQ-043 i_ready held at 1 with ACCEPT_TIMEOUT=16 -> o_start drops after 16 cycles, o_err=1, state ERROR, o_index=0.
REQ-044 i_go pulsed during word 4 -> no effect on sequence or timing; a second i_go after DONE reruns all 10 words and clears o_done at start.
REQ-045 i_rst asserted while in WAIT_DONE of word 5 -> next cycle o_start=0, o_index=0, o_busy=0, o_done=0.
REQ-046 N_REGS=1 -> one transfer of 16'h1E00, then DONE.
